// File: rtl/costas_loop_filter.sv
// rtl/costas_loop_filter.sv - PI loop filter for the Costas carrier-recovery loop.
// Optional lock detector is built when COSTAS_LOCK_DETECT_EN is defined.
module costas_loop_filter #(
  parameter int WIDTH        = 16,
  parameter int ACC_W        = 32,
  parameter int GAIN_BASE    = 12,
  parameter int LOCK_THRESH  = 256,
  parameter int LOCK_COUNT   = 1024,
  parameter int UNLOCK_COUNT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] error_tdata,
  input  logic                    error_tvalid,
  input  logic [3:0]              kp_shift,
  input  logic [3:0]              ki_shift,
  input  logic [ACC_W-1:0]        freq_center,
  output logic [ACC_W-1:0]        freq_tdata,
  output logic                    freq_tvalid,
  output logic                    integ_sat,
  output logic                    locked
);

  localparam logic signed [ACC_W-1:0] INT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] INT_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  logic                    acc;
  logic signed [ACC_W-1:0] e_s, p_term, i_inc, integ_next;
  logic signed [ACC_W:0]   sum;
  logic                    rail;

  logic signed [ACC_W-1:0] prop, integ, integ_d;
  logic                    s1_valid;

  assign acc = enable & error_tvalid & ~clear;

  always_comb begin
    e_s    = {{(ACC_W-WIDTH){error_tdata[WIDTH-1]}}, error_tdata} <<< GAIN_BASE;
    p_term = e_s >>> kp_shift;
    i_inc  = e_s >>> ki_shift;
    sum    = $signed({integ[ACC_W-1], integ}) + $signed({i_inc[ACC_W-1], i_inc});
    if (sum > SUM_MAX)
      integ_next = INT_MAX;
    else if (sum < SUM_MIN)
      integ_next = INT_MIN;
    else
      integ_next = sum[ACC_W-1:0];
    rail = (integ_next == INT_MAX) || (integ_next == INT_MIN);
  end

  // The output uses the integrator state from before the current sample (I path one sample behind P).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prop        <= '0;
      integ       <= '0;
      integ_d     <= '0;
      s1_valid    <= 1'b0;
      integ_sat   <= 1'b0;
      freq_tdata  <= '0;
      freq_tvalid <= 1'b0;
    end else if (clear) begin
      integ       <= '0;
      integ_d     <= '0;
      s1_valid    <= 1'b0;
      integ_sat   <= 1'b0;
      freq_tvalid <= 1'b0;
    end else begin
      s1_valid    <= acc;
      freq_tvalid <= s1_valid;
      if (acc) begin
        prop      <= p_term;
        integ_d   <= integ;
        integ     <= integ_next;
        integ_sat <= rail;
      end
      if (s1_valid)
        freq_tdata <= freq_center + prop + integ_d;
    end
  end

`ifdef COSTAS_LOCK_DETECT_EN
  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {SEARCH, LOCKED} lock_state_t;

  lock_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mag;
  logic             in_lock, out_lock;

  always_comb begin
    if (!error_tdata[WIDTH-1])
      mag = error_tdata;
    else if (error_tdata == {1'b1, {(WIDTH-1){1'b0}}})
      mag = {1'b0, {(WIDTH-1){1'b1}}};
    else
      mag = ~error_tdata + 1'b1;
    in_lock  = 32'(mag) < LOCK_THRESH;
    out_lock = 32'(mag) >= 2 * LOCK_THRESH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SEARCH;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (clear) begin
      state  <= SEARCH;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      locked <= (state == LOCKED);
      if (acc) begin
        case (state)
          SEARCH: begin
            if (!in_lock)
              cnt <= '0;
            else if (cnt == CNT_W'(LOCK_COUNT - 1)) begin
              state <= LOCKED;
              cnt   <= '0;
            end else
              cnt <= cnt + 1'b1;
          end
          default: begin
            if (!out_lock)
              cnt <= '0;
            else if (cnt == CNT_W'(UNLOCK_COUNT - 1)) begin
              state <= SEARCH;
              cnt   <= '0;
            end else
              cnt <= cnt + 1'b1;
          end
        endcase
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{LOCK_THRESH, LOCK_COUNT, UNLOCK_COUNT};
  assign locked      = 1'b0;
`endif

endmodule
